mult_result_accumulator: RTL and testbench

// - Downstream stage of the array multiplier: consumes its product stream (o_valid/Z_final) and sums ACC_LEN consecutive products.
// - Emits each finished sum via a valid/ready output port through a 2-entry first-word-fall-through (FWFT) buffer.
// - The multiplier cannot be stalled, so the input has no ready. A result that finds the buffer full is dropped and flagged.

---
 rtl/mult_result_accumulator_if.sv | 24 ++
 rtl/mult_result_accumulator.sv | 89 ++++++++
 tb/tb_mult_result_accumulator.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/mult_result_accumulator_if.sv
// Product-stream input and result valid/ready output bundle of mult_result_accumulator.
interface mult_result_accumulator_if #(
  parameter int DATAWIDTH = 4,
  parameter int ACC_WIDTH = 2*DATAWIDTH+2
);
  logic                   i_valid;
  logic [2*DATAWIDTH-1:0] i_product;
  logic                   i_clear;
  logic                   o_ready;
  logic                   o_valid;
  logic [ACC_WIDTH-1:0]   o_sum;
  logic                   o_partial;
  logic                   o_overflow;

  modport master (
    output i_valid, i_product, i_clear, o_ready,
    input  o_valid, o_sum, o_partial, o_overflow
  );

  modport slave (
    input  i_valid, i_product, i_clear, o_ready,
    output o_valid, o_sum, o_partial, o_overflow
  );
endinterface

// File: rtl/mult_result_accumulator.sv
// Sums ACC_LEN consecutive multiplier products and queues each sum in a 2-entry FWFT buffer.
// Define MULT_ACC_SAT_EN to saturate the running sum instead of wrapping.
module mult_result_accumulator #(
  parameter int DATAWIDTH = 4,
  parameter int ACC_LEN   = 4,
  parameter int ACC_WIDTH = 2*DATAWIDTH+2
) (
  input logic                    clk,
  input logic                    rst,
  mult_result_accumulator_if.slave bus
);
  localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACC_LEN-1);

  logic [CNT_W-1:0]     cnt;
  logic [ACC_WIDTH-1:0] acc;
  logic [ACC_WIDTH-1:0] base;
  logic [ACC_WIDTH-1:0] sum_nxt;
  logic                 accept;
  logic                 done;

  // A new group starts from zero rather than from the previous group's total.
  assign base   = (cnt == '0) ? '0 : acc;
  assign accept = bus.i_valid && !bus.i_clear;
  assign done   = accept && (cnt == CNT_LAST);

`ifdef MULT_ACC_SAT_EN
  logic [ACC_WIDTH:0] sum_wide;
  assign sum_wide = {1'b0, base} + (ACC_WIDTH+1)'(bus.i_product);
  assign sum_nxt  = sum_wide[ACC_WIDTH] ? '1 : sum_wide[ACC_WIDTH-1:0];
`else
  assign sum_nxt  = base + ACC_WIDTH'(bus.i_product);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      acc <= '0;
    end else if (bus.i_clear) begin
      cnt <= '0;
      acc <= '0;
    end else if (bus.i_valid) begin
      acc <= sum_nxt;
      cnt <= done ? '0 : cnt + CNT_W'(1);
    end
  end

  logic [ACC_WIDTH-1:0] mem [2];
  logic [1:0]           level;
  logic                 rd_ptr;
  logic                 wr_ptr;
  logic                 pop;
  logic                 full;
  logic                 push_ok;
  logic                 overflow;

  assign pop     = (level != 2'd0) && bus.o_ready;
  assign full    = (level == 2'd2);
  // When full, a same-cycle pop frees the head slot, which wr_ptr points at.
  assign push_ok = done && (!full || pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level    <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      overflow <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
    end else begin
      unique case ({push_ok, pop})
        2'b10:   level <= level + 2'd1;
        2'b01:   level <= level - 2'd1;
        default: level <= level;
      endcase
      if (pop)     rd_ptr <= ~rd_ptr;
      if (push_ok) begin
        wr_ptr      <= ~wr_ptr;
        mem[wr_ptr] <= sum_nxt;
      end
      if (done && full && !pop) overflow <= 1'b1;
    end
  end

  assign bus.o_valid    = (level != 2'd0);
  assign bus.o_sum      = (level != 2'd0) ? mem[rd_ptr] : '0;
  assign bus.o_partial  = (cnt != '0);
  assign bus.o_overflow = overflow;
endmodule

// File: tb/tb_mult_result_accumulator.sv
// Bench for mult_result_accumulator: 10-bit and 9-bit instances share stimulus and are checked against a queue model.
module tb_mult_result_accumulator;
  localparam int DW = 4;
  localparam int L  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mult_result_accumulator_if #(.DATAWIDTH(DW), .ACC_WIDTH(10)) ifa ();
  mult_result_accumulator_if #(.DATAWIDTH(DW), .ACC_WIDTH(9))  ifb ();

  assign ifb.i_valid   = ifa.i_valid;
  assign ifb.i_product = ifa.i_product;
  assign ifb.i_clear   = ifa.i_clear;
  assign ifb.o_ready   = ifa.o_ready;

  mult_result_accumulator #(.DATAWIDTH(DW), .ACC_LEN(L), .ACC_WIDTH(10)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa));
  mult_result_accumulator #(.DATAWIDTH(DW), .ACC_LEN(L), .ACC_WIDTH(9)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb));

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s act=%0d exp=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: running group sum, group position, and a list of up to two finished sums.
  int wid [2] = '{10, 9};
  int macc[2], mcnt[2], mn[2], movf[2];
  int mbuf[2][2];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 2; k++) begin
        macc[k] = 0; mcnt[k] = 0; mn[k] = 0; movf[k] = 0;
        mbuf[k][0] = 0; mbuf[k][1] = 0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        int s, mx;
        bit fin, pp;
        mx  = (1 << wid[k]) - 1;
        fin = 1'b0;
        pp  = (mn[k] > 0) && ifa.o_ready;
        if (ifa.i_clear) begin
          macc[k] = 0; mcnt[k] = 0;
        end else if (ifa.i_valid) begin
          s = ((mcnt[k] == 0) ? 0 : macc[k]) + int'(ifa.i_product);
`ifdef MULT_ACC_SAT_EN
          if (s > mx) s = mx;
`else
          s = s % (mx + 1);
`endif
          macc[k] = s;
          if (mcnt[k] == L-1) begin fin = 1'b1; mcnt[k] = 0; end
          else mcnt[k]++;
        end
        if (pp) begin mbuf[k][0] = mbuf[k][1]; mn[k]--; end
        if (fin) begin
          if (mn[k] < 2) begin mbuf[k][mn[k]] = macc[k]; mn[k]++; end
          else movf[k] = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("a_valid",    int'(ifa.o_valid),    int'(mn[0] > 0));
    chk("a_sum",      int'(ifa.o_sum),      (mn[0] > 0) ? mbuf[0][0] : 0);
    chk("a_partial",  int'(ifa.o_partial),  int'(mcnt[0] != 0));
    chk("a_overflow", int'(ifa.o_overflow), movf[0]);
    chk("b_valid",    int'(ifb.o_valid),    int'(mn[1] > 0));
    chk("b_sum",      int'(ifb.o_sum),      (mn[1] > 0) ? mbuf[1][0] : 0);
    chk("b_partial",  int'(ifb.o_partial),  int'(mcnt[1] != 0));
    chk("b_overflow", int'(ifb.o_overflow), movf[1]);
  end

  task automatic cyc(input bit v, input int p, input bit c);
    ifa.i_valid   = v;
    ifa.i_product = 8'(p);
    ifa.i_clear   = c;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    ifa.i_valid = 1'b0; ifa.i_clear = 1'b0; ifa.i_product = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    int n;
    ifa.i_valid = 1'b0; ifa.i_product = '0; ifa.i_clear = 1'b0; ifa.o_ready = 1'b1;
    #1;
    chk("rst_valid",    int'(ifa.o_valid),    0);
    chk("rst_sum",      int'(ifa.o_sum),      0);
    chk("rst_partial",  int'(ifa.o_partial),  0);
    chk("rst_overflow", int'(ifa.o_overflow), 0);
    do_reset();

    // Basic group of 225s, also exercising the 9-bit width.
    ifa.o_ready = 1'b1;
    cyc(1, 225, 0);
    chk("basic_partial1", int'(ifa.o_partial), 1);
    cyc(1, 225, 0); cyc(1, 225, 0);
    chk("basic_nores", int'(ifa.o_valid), 0);
    cyc(1, 225, 0);
    chk("basic_valid",   int'(ifa.o_valid),   1);
    chk("basic_sum",     int'(ifa.o_sum),     900);
    chk("basic_partial", int'(ifa.o_partial), 0);
`ifdef MULT_ACC_SAT_EN
    chk("width9_sum", int'(ifb.o_sum), 511);
`else
    chk("width9_sum", int'(ifb.o_sum), 388);
`endif
    cyc(0, 0, 0);
    chk("basic_pulse", int'(ifa.o_valid), 0);

    // Gaps, then a clear that also carries a product.
    cyc(1, 10, 0); cyc(0, 0, 0); cyc(0, 0, 0); cyc(1, 20, 0); cyc(0, 0, 0);
    cyc(1, 99, 1);
    chk("clear_partial", int'(ifa.o_partial), 0);
    chk("clear_nores",   int'(ifa.o_valid),   0);
    cyc(1, 1, 0); cyc(1, 2, 0); cyc(1, 3, 0); cyc(1, 4, 0);
    chk("clear_valid", int'(ifa.o_valid), 1);
    chk("clear_sum",   int'(ifa.o_sum),   10);
    cyc(0, 0, 0);

    // Backpressure: third group dropped.
    do_reset();
    ifa.o_ready = 1'b0;
    for (int i = 0; i < 12; i++) cyc(1, 1, 0);
    chk("bp_overflow", int'(ifa.o_overflow), 1);
    chk("bp_sum",      int'(ifa.o_sum),      4);
    ifa.o_ready = 1'b1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (ifa.o_valid) n++;
      cyc(0, 0, 0);
    end
    chk("bp_drained",   n,                      2);
    chk("bp_empty",     int'(ifa.o_valid),      0);
    chk("bp_ovf_stick", int'(ifa.o_overflow),   1);

    // Full buffer with a pop on the completion edge.
    do_reset();
    ifa.o_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    for (int i = 0; i < 4; i++) cyc(1, 2, 0);
    for (int i = 0; i < 3; i++) cyc(1, 3, 0);
    chk("fp_head0", int'(ifa.o_sum), 4);
    ifa.o_ready = 1'b1;
    cyc(1, 3, 0);
    chk("fp_head1",    int'(ifa.o_sum),      8);
    chk("fp_overflow", int'(ifa.o_overflow), 0);
    cyc(0, 0, 0);
    chk("fp_head2", int'(ifa.o_sum), 12);
    cyc(0, 0, 0);
    chk("fp_empty", int'(ifa.o_valid), 0);

    // Asynchronous reset mid-group with a buffered result.
    do_reset();
    ifa.o_ready = 1'b0;
    for (int i = 0; i < 4; i++) cyc(1, 1, 0);
    cyc(1, 7, 0); cyc(1, 7, 0);
    ifa.i_valid = 1'b0;
    chk("mr_pre_valid",   int'(ifa.o_valid),   1);
    chk("mr_pre_partial", int'(ifa.o_partial), 1);
    #1; rst = 1'b1; #1;
    chk("mr_valid",   int'(ifa.o_valid),   0);
    chk("mr_sum",     int'(ifa.o_sum),     0);
    chk("mr_partial", int'(ifa.o_partial), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ifa.o_ready = 1'b1;
    for (int i = 0; i < 4; i++) cyc(1, 5, 0);
    chk("mr_sum20", int'(ifa.o_sum), 20);
    cyc(0, 0, 0);

    // Randomized traffic with phases of heavy backpressure.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if ((i % 400) < 300) ifa.o_ready = ($urandom_range(0, 3) != 0);
      else                 ifa.o_ready = ($urandom_range(0, 9) == 0);
      cyc($urandom_range(0, 9) < 7, int'($urandom_range(0, 255)), $urandom_range(0, 49) == 0);
    end
    ifa.i_valid = 1'b0; ifa.i_clear = 1'b0;
    @(posedge clk); #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
